// File: rtl/dma_pkg.sv
// Shared definitions for the dma_master copy engine: register offsets,
// CTRL/STAT bit positions, FSM states and the byte-enable merge helper.
package dma_pkg;

   localparam logic [1:0] SRC_OFF  = 2'd0;
   localparam logic [1:0] DST_OFF  = 2'd1;
   localparam logic [1:0] LEN_OFF  = 2'd2;
   localparam logic [1:0] CTRL_OFF = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_BUSY  = 1;
   localparam int CTRL_DONE  = 2;
   localparam int CTRL_ERR   = 3;
   localparam int CTRL_ABORT = 4;
   localparam int CTRL_IE    = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4
   } dma_state_e;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_master_regs.sv
// Slave register file of dma_master: SRC/DST/LEN, sticky DONE/ERR, START/ABORT pulses.
// Optional DMA_MASTER_IRQ_EN adds the IE bit and irq_o.
module dma_master_regs
   import dma_pkg::*;
#(
   parameter int LEN_W = 16
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o,
   input  logic             busy_i,
   input  logic             done_set_i,
   input  logic             err_set_i,
   output logic [31:0]      src_o,
   output logic [31:0]      dst_o,
   output logic [LEN_W-1:0] len_o,
   output logic             start_o,
   output logic             abort_o
`ifdef DMA_MASTER_IRQ_EN
   ,
   output logic             irq_o
`endif
);

   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             ie_rd_s;
   logic [1:0]       off_s;
   logic             ctrl_wr_s;
   logic             unused_addr_s;

   assign off_s         = addr_i[3:2];
   assign unused_addr_s = ^{addr_i[31:4], addr_i[1:0]};
   assign ctrl_wr_s     = we_i & (off_s == CTRL_OFF) & be_i[0];
   assign start_o       = ctrl_wr_s & wdata_i[CTRL_START] & ~busy_i;
   // A write carrying both START and ABORT is treated as a START only.
   assign abort_o       = ctrl_wr_s & wdata_i[CTRL_ABORT] & ~wdata_i[CTRL_START];

`ifdef DMA_MASTER_IRQ_EN
   logic ie_q, ie_d;

   always_comb begin
      if (ctrl_wr_s) begin
         ie_d = wdata_i[CTRL_IE];
      end else begin
         ie_d = ie_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ie_q <= 1'b0;
      end else begin
         ie_q <= ie_d;
      end
   end

   assign ie_rd_s = ie_q;
   assign irq_o   = (done_q | err_q) & ie_q;
`else
   assign ie_rd_s = 1'b0;
`endif

   always_comb begin
      src_d = src_q;
      dst_d = dst_q;
      len_d = len_q;
      if (we_i && !busy_i) begin
         case (off_s)
            SRC_OFF: src_d = be_merge(src_q, wdata_i, be_i) & 32'hFFFF_FFFC;
            DST_OFF: dst_d = be_merge(dst_q, wdata_i, be_i) & 32'hFFFF_FFFC;
            LEN_OFF: len_d = LEN_W'(be_merge(32'(len_q), wdata_i, be_i));
            default: len_d = len_q;
         endcase
      end else begin
         len_d = len_q;
      end

      // Completion in the same cycle as a W1C keeps the flag set.
      if (done_set_i) begin
         done_d = 1'b1;
      end else if (ctrl_wr_s && wdata_i[CTRL_DONE]) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end

      if (err_set_i) begin
         err_d = 1'b1;
      end else if (ctrl_wr_s && wdata_i[CTRL_ERR]) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q  <= 32'd0;
         dst_q  <= 32'd0;
         len_q  <= {LEN_W{1'b0}};
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         src_q  <= src_d;
         dst_q  <= dst_d;
         len_q  <= len_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      case (off_s)
         SRC_OFF:  rdata_o = src_q;
         DST_OFF:  rdata_o = dst_q;
         LEN_OFF:  rdata_o = 32'(len_q);
         CTRL_OFF: rdata_o = {26'd0, ie_rd_s, 1'b0, err_q, done_q, busy_i, 1'b0};
         default:  rdata_o = 32'd0;
      endcase
   end

   assign src_o = src_q;
   assign dst_o = dst_q;
   assign len_o = len_q;

endmodule

// File: rtl/dma_master.sv
// Single-channel memory-to-memory copy engine: read-then-write per word on the
// req/gnt/rvalid initiator port. Optional DMA_MASTER_IRQ_EN adds irq_o.
module dma_master
   import dma_pkg::*;
#(
   parameter int LEN_W    = 16,
   parameter int MAX_WAIT = 255
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        m_req_o,
   output logic        m_we_o,
   output logic [3:0]  m_be_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   input  logic        m_gnt_i,
   input  logic        m_rvalid_i,
   input  logic [31:0] m_rdata_i
`ifdef DMA_MASTER_IRQ_EN
   ,
   output logic        irq_o
`endif
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   dma_state_e       state_q, state_d;
   logic [31:0]      cur_src_q, cur_src_d;
   logic [31:0]      cur_dst_q, cur_dst_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [31:0]      buf_q, buf_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic             abort_pend_q, abort_pend_d;

   logic [31:0]      src_s, dst_s;
   logic [LEN_W-1:0] len_s;
   logic             start_s, abort_s, abort_now_s, timeout_s;
   logic             busy_s, done_set_s, err_set_s;

   dma_master_regs #(.LEN_W(LEN_W)) u_regs (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (we_i),
      .be_i       (be_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .busy_i     (busy_s),
      .done_set_i (done_set_s),
      .err_set_i  (err_set_s),
      .src_o      (src_s),
      .dst_o      (dst_s),
      .len_o      (len_s),
      .start_o    (start_s),
      .abort_o    (abort_s)
`ifdef DMA_MASTER_IRQ_EN
      ,
      .irq_o      (irq_o)
`endif
   );

   assign busy_s      = (state_q != IDLE);
   assign abort_now_s = abort_pend_q | abort_s;
   assign timeout_s   = (wait_q == WAIT_W'(MAX_WAIT - 1));

   // ABORT is only honoured at a response so an issued request always completes.
   always_comb begin
      state_d    = state_q;
      cur_src_d  = cur_src_q;
      cur_dst_d  = cur_dst_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      wait_d     = wait_q + WAIT_W'(1);
      done_set_s = 1'b0;
      err_set_s  = 1'b0;
      case (state_q)
         IDLE: begin
            wait_d = {WAIT_W{1'b0}};
            if (start_s && (len_s == {LEN_W{1'b0}})) begin
               done_set_s = 1'b1;
            end else if (start_s) begin
               state_d   = RD_REQ;
               cur_src_d = src_s;
               cur_dst_d = dst_s;
               cnt_d     = len_s;
            end else begin
               state_d = IDLE;
            end
         end
         RD_REQ, WR_REQ: begin
            if (m_gnt_i) begin
               wait_d  = {WAIT_W{1'b0}};
               state_d = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
            end else if (timeout_s) begin
               state_d   = IDLE;
               err_set_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         RD_WAIT: begin
            if (m_rvalid_i) begin
               buf_d  = m_rdata_i;
               wait_d = {WAIT_W{1'b0}};
               if (abort_now_s) begin
                  state_d   = IDLE;
                  err_set_s = 1'b1;
               end else begin
                  state_d = WR_REQ;
               end
            end else if (timeout_s) begin
               state_d   = IDLE;
               err_set_s = 1'b1;
            end else begin
               state_d = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (m_rvalid_i) begin
               cur_src_d = cur_src_q + 32'd4;
               cur_dst_d = cur_dst_q + 32'd4;
               cnt_d     = cnt_q - LEN_W'(1);
               wait_d    = {WAIT_W{1'b0}};
               if (abort_now_s) begin
                  state_d   = IDLE;
                  err_set_s = 1'b1;
               end else if (cnt_q == LEN_W'(1)) begin
                  state_d    = IDLE;
                  done_set_s = 1'b1;
               end else begin
                  state_d = RD_REQ;
               end
            end else if (timeout_s) begin
               state_d   = IDLE;
               err_set_s = 1'b1;
            end else begin
               state_d = WR_WAIT;
            end
         end
         default: begin
            state_d = IDLE;
            wait_d  = {WAIT_W{1'b0}};
         end
      endcase

      if (state_d == IDLE) begin
         abort_pend_d = 1'b0;
      end else if (abort_s) begin
         abort_pend_d = 1'b1;
      end else begin
         abort_pend_d = abort_pend_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cur_src_q    <= 32'd0;
         cur_dst_q    <= 32'd0;
         cnt_q        <= {LEN_W{1'b0}};
         buf_q        <= 32'd0;
         wait_q       <= {WAIT_W{1'b0}};
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_src_q    <= cur_src_d;
         cur_dst_q    <= cur_dst_d;
         cnt_q        <= cnt_d;
         buf_q        <= buf_d;
         wait_q       <= wait_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   always_comb begin
      m_req_o = 1'b0;
      m_we_o  = 1'b0;
      case (state_q)
         RD_REQ:  m_req_o = 1'b1;
         WR_REQ: begin
            m_req_o = 1'b1;
            m_we_o  = 1'b1;
         end
         WR_WAIT: m_we_o = 1'b1;
         default: m_req_o = 1'b0;
      endcase
   end

   assign m_be_o    = 4'hF;
   assign m_addr_o  = m_we_o ? cur_dst_q : cur_src_q;
   assign m_wdata_o = buf_q;

endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: bus responder with memory model, expected
// transaction queue derived from the copy rules, directed and random transfers.
module tb_dma_master;

   localparam int LEN_W    = 16;
   localparam int MAX_WAIT = 8;
   localparam logic [31:0] A_SRC  = 32'h0;
   localparam logic [31:0] A_DST  = 32'h4;
   localparam logic [31:0] A_LEN  = 32'h8;
   localparam logic [31:0] A_CTRL = 32'hC;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr, wdata, rdata;
   logic        m_req, m_we, m_gnt, m_rvalid;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef DMA_MASTER_IRQ_EN
   logic        irq;
`endif

   typedef struct {
      bit        we;
      bit [31:0] addr;
      bit [31:0] data;
   } txn_t;

   txn_t      exp_q[$];
   bit [31:0] src_vals[$];
   bit [31:0] mem [bit [31:0]];

   int checks = 0;
   int errors = 0;

   int stall_rd_idx, stall_wr_idx, stall_len, resp_delay;
   bit stall_rand, no_resp;
   int rd_cnt, wr_cnt, txn_cnt, req_cycles = 0;
   int resp_cd = 0, stall_left = 0;
   bit in_req = 1'b0;
   bit hold_we;
   logic [31:0] hold_addr, resp_data;

   always #5 clk = ~clk;

   dma_master #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (we),
      .be_i       (be),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .rdata_o    (rdata),
      .m_req_o    (m_req),
      .m_we_o     (m_we),
      .m_be_o     (m_be),
      .m_addr_o   (m_addr),
      .m_wdata_o  (m_wdata),
      .m_gnt_i    (m_gnt),
      .m_rvalid_i (m_rvalid),
      .m_rdata_i  (m_rdata)
`ifdef DMA_MASTER_IRQ_EN
      ,
      .irq_o      (irq)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] mem_rd(input bit [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Bus responder: grants (optionally after a stall) and answers one cycle later.
   initial begin : responder
      int idx;
      txn_t e;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
      forever begin
         @(negedge clk);
         m_rvalid = 1'b0;
         if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
               m_rvalid = 1'b1;
               m_rdata  = resp_data;
            end
         end
         m_gnt = 1'b0;
         if (m_req === 1'b1) begin
            req_cycles++;
            if (!in_req) begin
               in_req = 1'b1; hold_addr = m_addr; hold_we = m_we;
               idx = m_we ? wr_cnt : rd_cnt;
               if (m_we ? (idx == stall_wr_idx) : (idx == stall_rd_idx)) stall_left = stall_len;
               else if (stall_rand) stall_left = int'($urandom_range(0, 3));
               else stall_left = 0;
            end else begin
               chk("hold_addr", m_addr, hold_addr);
               chk("hold_we", {31'd0, m_we}, {31'd0, hold_we});
            end
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               m_gnt = 1'b1; in_req = 1'b0; txn_cnt++;
               chk("txn_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("txn_we", {31'd0, m_we}, {31'd0, e.we});
                  chk("txn_addr", m_addr, e.addr);
                  if (e.we) chk("txn_wdata", m_wdata, e.data);
               end
               if (m_we) begin
                  mem[m_addr] = m_wdata; wr_cnt++; resp_data = 32'd0;
               end else begin
                  resp_data = mem_rd(m_addr); rd_cnt++;
               end
               if (!no_resp) resp_cd = resp_delay;
            end
         end
      end
   end

   task automatic reset_resp();
      stall_rd_idx = -1; stall_wr_idx = -1; stall_len = 0; stall_rand = 1'b0;
      no_resp = 1'b0; resp_delay = 1; rd_cnt = 0; wr_cnt = 0; txn_cnt = 0;
      in_req = 1'b0; resp_cd = 0;
   endtask

   task automatic reg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      we = 1'b1; addr = a; wdata = d; be = b;
      @(posedge clk);
      #1 we = 1'b0;
   endtask

   task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1 d = rdata;
   endtask

   task automatic setup(input logic [31:0] s, input logic [31:0] d, input int n);
      bit [31:0] v;
      reg_write(A_CTRL, 32'hC, 4'h1);
      reg_write(A_SRC, s, 4'hF);
      reg_write(A_DST, d, 4'hF);
      reg_write(A_LEN, 32'(n), 4'hF);
      exp_q.delete(); src_vals.delete();
      for (int i = 0; i < n; i++) begin
         v = mem_rd(s + 32'(4 * i));
         src_vals.push_back(v);
         exp_q.push_back('{we: 1'b0, addr: s + 32'(4 * i), data: 32'd0});
         exp_q.push_back('{we: 1'b1, addr: d + 32'(4 * i), data: v});
      end
   endtask

   task automatic check_dst(input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) chk("dst_word", mem_rd(d + 32'(4 * i)), src_vals[i]);
   endtask

   task automatic wait_idle(input int budget);
      logic [31:0] c;
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1 reg_read(A_CTRL, c);
         if (c[1] == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_wait", {31'd0, ok}, 32'd1);
   endtask

   initial begin : main
      logic [31:0] d, s_r, d_r, orig;
      int rc0, n;
      bit found;
      rst = 1'b1; we = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0;
      reset_resp();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_req", {31'd0, m_req}, 32'd0);
      chk("rst_we", {31'd0, m_we}, 32'd0);
      chk("rst_addr", m_addr, 32'd0);
      chk("rst_wdata", m_wdata, 32'd0);
      chk("m_be", {28'd0, m_be}, 32'hF);
      for (int k = 0; k < 4; k++) begin
         reg_read(32'(4 * k), d);
         chk("rst_reg", d, 32'd0);
      end

      // byte-enable writes, alignment and LEN width
      reg_write(A_SRC, 32'hFFFF_FFFF, 4'hF); reg_read(A_SRC, d); chk("src_align", d, 32'hFFFF_FFFC);
      reg_write(A_SRC, 32'h1234_5678, 4'h5); reg_read(A_SRC, d); chk("src_be", d, 32'hFF34_FF78);
      reg_write(A_DST, 32'hAABB_CCDF, 4'h8); reg_read(A_DST, d); chk("dst_be", d, 32'hAA00_0000);
      reg_write(A_LEN, 32'hABCD_1234, 4'hF); reg_read(A_LEN, d); chk("len_w", d, 32'h0000_1234);
      reg_write(A_LEN, 32'h0000_FF00, 4'h2); reg_read(A_LEN, d); chk("len_be", d, 32'h0000_FF34);
      reg_write(A_CTRL, 32'h20, 4'h1); reg_read(A_CTRL, d);
`ifdef DMA_MASTER_IRQ_EN
      chk("ctrl_ie", d, 32'h20);
`else
      chk("ctrl_ie", d, 32'h0);
`endif
      reg_write(A_CTRL, 32'h0, 4'h1);

      // basic 3-word copy with exact latency
      reset_resp();
      setup(32'h100, 32'h4000, 3);
      reg_write(A_CTRL, 32'h1, 4'h1);
      repeat (11) @(posedge clk);
      #1 reg_read(A_CTRL, d); chk("basic_busy", d, 32'h2);
      @(posedge clk);
      #1 reg_read(A_CTRL, d); chk("basic_done", d, 32'h4);
      chk("basic_txns", 32'(txn_cnt), 32'd6);
      chk("basic_left", 32'(exp_q.size()), 32'd0);
      check_dst(32'h4000, 3);
`ifdef DMA_MASTER_IRQ_EN
      chk("irq_off", {31'd0, irq}, 32'd0);
      reg_write(A_CTRL, 32'h20, 4'h1);
      #1 chk("irq_on", {31'd0, irq}, 32'd1);
      reg_write(A_CTRL, 32'h0, 4'h1);
`endif

      // LEN = 0
      reset_resp();
      setup(32'h200, 32'h5000, 0);
      rc0 = req_cycles;
      reg_write(A_CTRL, 32'h1, 4'h1);
      reg_read(A_CTRL, d); chk("len0_done", d, 32'h4);
      repeat (4) @(posedge clk);
      chk("len0_noreq", 32'(req_cycles - rc0), 32'd0);

      // read stall, writes and START while busy ignored
      reset_resp();
      stall_rd_idx = 1; stall_len = 5;
      setup(32'h100, 32'h6000, 3);
      rc0 = req_cycles;
      reg_write(A_CTRL, 32'h1, 4'h1);
      reg_write(A_SRC, 32'hDEAD_BEEC, 4'hF);
      reg_write(A_CTRL, 32'h1, 4'h1);
      wait_idle(100);
      reg_read(A_CTRL, d); chk("stall_done", d, 32'h4);
      reg_read(A_SRC, d); chk("src_locked", d, 32'h100);
      chk("stall_txns", 32'(txn_cnt), 32'd6);
      chk("stall_reqcyc", 32'(req_cycles - rc0), 32'd11);
      check_dst(32'h6000, 3);

      // ABORT during WR_REQ of word 2
      reset_resp();
      stall_wr_idx = 1; stall_len = 6;
      setup(32'h300, 32'h7000, 4);
      orig = mem_rd(32'h7008);
      reg_write(A_CTRL, 32'h1, 4'h1);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (m_req && m_we && wr_cnt == 1) begin
            found = 1'b1;
            break;
         end
      end
      chk("abort_reach", {31'd0, found}, 32'd1);
      reg_write(A_CTRL, 32'h10, 4'h1);
      wait_idle(100);
      rc0 = req_cycles;
      repeat (4) @(posedge clk);
      #1 reg_read(A_CTRL, d); chk("abort_stat", d, 32'h8);
      chk("abort_noreq", 32'(req_cycles - rc0), 32'd0);
      chk("abort_txns", 32'(txn_cnt), 32'd4);
      check_dst(32'h7000, 2);
      chk("abort_untouched", mem_rd(32'h7008), orig);

      // response timeout
      reset_resp();
      no_resp = 1'b1;
      setup(32'h400, 32'h8000, 2);
      reg_write(A_CTRL, 32'h1, 4'h1);
      repeat (8) @(posedge clk);
      #1 reg_read(A_CTRL, d); chk("tmo_busy", d, 32'h2);
      @(posedge clk);
      #1 reg_read(A_CTRL, d); chk("tmo_err", d, 32'h8);
      chk("tmo_req", {31'd0, m_req}, 32'd0);
      reg_write(A_CTRL, 32'h8, 4'h1);
      reg_read(A_CTRL, d); chk("err_w1c", d, 32'h0);

      // reset during RD_WAIT, late response
      reset_resp();
      resp_delay = 2;
      setup(32'h500, 32'h9000, 2);
      reg_write(A_CTRL, 32'h1, 4'h1);
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mrst_req", {31'd0, m_req}, 32'd0);
      chk("mrst_addr", m_addr, 32'd0);
      chk("mrst_wdata", m_wdata, 32'd0);
      for (int k = 0; k < 4; k++) begin
         reg_read(32'(4 * k), d);
         chk("mrst_reg", d, 32'd0);
      end
      rc0 = req_cycles;
      repeat (4) @(posedge clk);
      #1 reg_read(A_CTRL, d); chk("mrst_ctrl", d, 32'd0);
      chk("mrst_noreq", 32'(req_cycles - rc0), 32'd0);
`ifdef DMA_MASTER_IRQ_EN
      chk("mrst_irq", {31'd0, irq}, 32'd0);
`endif

      // randomized transfers with random grant stalls (first one wraps at 2^32)
      for (int it = 0; it < 16; it++) begin
         reset_resp();
         stall_rand = 1'b1;
         if (it == 0) begin
            s_r = 32'hFFFF_FFF8; d_r = 32'h3000_0000; n = 3;
         end else begin
            s_r = 32'h1000_0000 + ($urandom_range(0, 255) << 2);
            d_r = 32'h2000_0000 + ($urandom_range(0, 255) << 2);
            n   = int'($urandom_range(0, 6));
         end
         setup(s_r, d_r, n);
         reg_write(A_CTRL, 32'h1, 4'h1);
         wait_idle(200);
         reg_read(A_CTRL, d); chk("rnd_done", d, 32'h4);
         chk("rnd_txns", 32'(txn_cnt), 32'(2 * n));
         reg_read(A_LEN, d); chk("rnd_len_kept", d, 32'(n));
         reg_read(A_SRC, d); chk("rnd_src_kept", d, s_r);
         check_dst(d_r, n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
